// File: rtl/countdown_timer.sv
// Loadable, cascadable down-counter with IDLE/RUN control, one-shot or auto-reload.
// Optional terminal-event counter output enabled by defining COUNTDOWN_EVENT_CNT_EN.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_in,
  input  logic             load,
  input  logic             enable,
  input  logic             start,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             b_out,
  output logic             busy,
  output logic             done
`ifdef COUNTDOWN_EVENT_CNT_EN
  ,
  output logic [7:0]       event_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic [WIDTH-1:0] count_next;
  logic             done_next;
  logic             terminal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      done   <= done_next;
    end
  end

  // Priority within one edge: load, then start, then counting.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    done_next   = 1'b0;
    terminal    = (state == RUN) && enable && (count == '0) && !load;

    if (load) begin
      reload_next = load_in;
      count_next  = load_in;
      state_next  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (reload != '0) begin
              count_next = reload;
              state_next = RUN;
            end else begin
              // Zero-length interval: report the event without ever running.
              done_next = 1'b1;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (count != '0) begin
              count_next = count - WIDTH'(1);
            end else begin
              done_next = 1'b1;
              if (auto_reload) begin
                count_next = reload;
              end else begin
                state_next = IDLE;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state == RUN);
    b_out = terminal;
  end

`ifdef COUNTDOWN_EVENT_CNT_EN
  // Saturating count of terminal events, advanced on the edge that raises done.
  always_ff @(posedge clk) begin
    if (!reset || load) begin
      event_cnt <= 8'd0;
    end else if (done_next && (event_cnt != 8'hFF)) begin
      event_cnt <= event_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: two chained instances, an abstract
// per-instance model compared every cycle, plus directed literal expectations.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] load_in1, load_in2;
  logic         load1, load2, enable1, start1, start2, auto1, auto2;
  logic [W-1:0] count1, count2;
  logic         b_out1, b_out2, busy1, busy2, done1, done2;
`ifdef COUNTDOWN_EVENT_CNT_EN
  logic [7:0]   event_cnt1, event_cnt2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W)) u1 (
    .clk(clk), .reset(reset), .load_in(load_in1), .load(load1),
    .enable(enable1), .start(start1), .auto_reload(auto1),
    .count(count1), .b_out(b_out1), .busy(busy1), .done(done1)
`ifdef COUNTDOWN_EVENT_CNT_EN
    , .event_cnt(event_cnt1)
`endif
  );

  // Second stage counts first-stage terminal events.
  countdown_timer #(.WIDTH(W)) u2 (
    .clk(clk), .reset(reset), .load_in(load_in2), .load(load2),
    .enable(b_out1), .start(start2), .auto_reload(auto2),
    .count(count2), .b_out(b_out2), .busy(busy2), .done(done2)
`ifdef COUNTDOWN_EVENT_CNT_EN
    , .event_cnt(event_cnt2)
`endif
  );

  typedef struct {
    bit running;
    int remaining;
    int reload;
    bit done;
    int events;
  } mdl_t;

  mdl_t m1, m2;
  bit   started = 1'b0;
  bit   mb1;

  function automatic mdl_t model_next(mdl_t m, bit rst, bit ld, int din,
                                      bit st, bit en, bit ar);
    mdl_t n;
    n = m;
    n.done = 1'b0;
    if (!rst) begin
      n = '{default: 0};
    end else if (ld) begin
      n.running   = 1'b0;
      n.remaining = din;
      n.reload    = din;
      n.events    = 0;
    end else if (!m.running) begin
      if (st) begin
        if (m.reload == 0) n.done = 1'b1;
        else begin
          n.running   = 1'b1;
          n.remaining = m.reload;
        end
      end
    end else if (en) begin
      if (m.remaining > 0) n.remaining = m.remaining - 1;
      else begin
        n.done      = 1'b1;
        n.running   = ar;
        n.remaining = ar ? m.reload : 0;
      end
    end
    if (n.done && n.events < 255) n.events = n.events + 1;
    return n;
  endfunction

  function automatic bit model_b_out(mdl_t m, bit ld, bit en);
    return m.running && (m.remaining == 0) && en && !ld;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    mb1 = model_b_out(m1, load1, enable1);
    m1 = model_next(m1, reset, load1, int'(load_in1), start1, enable1, auto1);
    m2 = model_next(m2, reset, load2, int'(load_in2), start2, mb1, auto2);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_count1", int'(count1), m1.remaining);
      check("m_busy1",  int'(busy1),  int'(m1.running));
      check("m_done1",  int'(done1),  int'(m1.done));
      check("m_bout1",  int'(b_out1), int'(model_b_out(m1, load1, enable1)));
      check("m_count2", int'(count2), m2.remaining);
      check("m_busy2",  int'(busy2),  int'(m2.running));
      check("m_done2",  int'(done2),  int'(m2.done));
      check("m_bout2",  int'(b_out2),
            int'(model_b_out(m2, load2, model_b_out(m1, load1, enable1))));
`ifdef COUNTDOWN_EVENT_CNT_EN
      check("m_evt1", int'(event_cnt1), m1.events);
      check("m_evt2", int'(event_cnt2), m2.events);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input bit ld, input logic [W-1:0] din, input bit st,
                      input bit en, input bit ar);
    load1 = ld; load_in1 = din; start1 = st; enable1 = en; auto1 = ar;
  endtask

  task automatic set2(input bit ld, input logic [W-1:0] din, input bit st,
                      input bit ar);
    load2 = ld; load_in2 = din; start2 = st; auto2 = ar;
  endtask

  initial begin
    int exp_c[6] = '{1, 0, 2, 1, 0, 2};
    int exp_d[6] = '{0, 0, 1, 0, 0, 1};
    int g_en[5]  = '{1, 0, 1, 0, 1};
    int g_c1[5]  = '{0, 0, 1, 1, 0};
    int g_d1[5]  = '{0, 0, 1, 0, 0};
    int g_c2[5]  = '{2, 2, 1, 1, 1};

    // Reset held two cycles with a competing load.
    reset = 1'b0;
    set1(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    set2(1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    tick();
    check("rst_count", int'(count1), 0);
    check("rst_busy",  int'(busy1),  0);
    check("rst_done",  int'(done1),  0);
    #1 check("rst_bout", int'(b_out1), 0);
    reset = 1'b1;

    // One-shot from 3.
    set1(1'b1, 4'd3, 1'b0, 1'b0, 1'b0); tick();
    check("os_load", int'(count1), 3);
    set1(1'b0, 4'd0, 1'b1, 1'b1, 1'b0); tick();
    check("os_start_cnt",  int'(count1), 3);
    check("os_start_busy", int'(busy1),  1);
    set1(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i >= 0; i--) begin
      tick();
      check("os_count", int'(count1), i);
    end
    #1 check("os_bout", int'(b_out1), 1);
    tick();
    check("os_done", int'(done1), 1);
    check("os_busy", int'(busy1), 0);
    check("os_hold", int'(count1), 0);
    tick();
    check("os_done_off", int'(done1), 0);

    // Auto-reload from 2: period 3.
    set1(1'b1, 4'd2, 1'b0, 1'b0, 1'b1); tick();
    set1(1'b0, 4'd0, 1'b1, 1'b1, 1'b1); tick();
    check("ar_start", int'(count1), 2);
    set1(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ar_count", int'(count1), exp_c[i]);
      check("ar_done",  int'(done1),  exp_d[i]);
      check("ar_busy",  int'(busy1),  1);
    end

    // Start while running is ignored.
    set1(1'b0, 4'd0, 1'b1, 1'b0, 1'b1); tick();
    check("run_start_ign", int'(count1), 2);

    // Load during the terminal cycle suppresses b_out and done.
    set1(1'b1, 4'd1, 1'b0, 1'b0, 1'b0); tick();
    set1(1'b0, 4'd0, 1'b1, 1'b1, 1'b0); tick();
    tick();
    check("lt_zero", int'(count1), 0);
    set1(1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    #1 check("lt_bout", int'(b_out1), 0);
    tick();
    check("lt_done",  int'(done1),  0);
    check("lt_count", int'(count1), 6);

    // Load + start together in RUN at count 5.
    set1(1'b1, 4'd5, 1'b0, 1'b0, 1'b0); tick();
    set1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    check("pr_run5", int'(count1), 5);
    set1(1'b1, 4'd7, 1'b1, 1'b1, 1'b0); tick();
    check("pr_count", int'(count1), 7);
    check("pr_busy",  int'(busy1),  0);
    check("pr_done",  int'(done1),  0);
    set1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    check("pr_reload", int'(count1), 7);

    // Reset mid-run aborts without done.
    reset = 1'b0;
    set1(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); tick();
    reset = 1'b1;
    check("mr_count", int'(count1), 0);
    check("mr_busy",  int'(busy1),  0);
    tick();
    check("mr_done", int'(done1), 0);

    // Gated enable with cascade into stage 2.
    set1(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    set2(1'b1, 4'd2, 1'b0, 1'b0); tick();
    set1(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    set2(1'b0, 4'd0, 1'b1, 1'b0); tick();
    set2(1'b0, 4'd0, 1'b0, 1'b0);
    check("cs_c1", int'(count1), 1);
    check("cs_c2", int'(count2), 2);
    for (int i = 0; i < 5; i++) begin
      set1(1'b0, 4'd0, 1'b0, g_en[i] != 0, 1'b1);
      tick();
      check("cs_gate_c1", int'(count1), g_c1[i]);
      check("cs_gate_d1", int'(done1),  g_d1[i]);
      check("cs_gate_c2", int'(count2), g_c2[i]);
    end
    set1(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    check("cs_c2_dec", int'(count2), 0);
    tick();
    tick();
    check("cs_done2", int'(done2), 1);
    check("cs_busy2", int'(busy2), 0);
    check("cs_c1_rl", int'(count1), 1);

    // Zero reload: done without running.
    set1(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    set1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    check("z_done", int'(done1), 1);
    check("z_busy", int'(busy1), 0);
    check("z_cnt",  int'(count1), 0);
`ifdef COUNTDOWN_EVENT_CNT_EN
    check("z_evt", int'(event_cnt1), 1);
`endif
    set1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    check("z_done_off", int'(done1), 0);
    check("z_busy_off", int'(busy1), 0);

`ifdef COUNTDOWN_EVENT_CNT_EN
    set1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (300) tick();
    check("evt_sat", int'(event_cnt1), 255);
    set1(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    check("evt_clr", int'(event_cnt1), 0);
`endif

    set1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
